// File: rtl/rp_dma_ctrl_regs.sv
// DMA control register slave: AXI4-Lite config/status registers plus a small FSM that
// hands one latched command to the DMA engine, waits for done, and holds an IRQ until acked.
module rp_dma_ctrl_regs #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DMA_ADDR_WIDTH = 64,
   parameter int LEN_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
   input  logic                      s_axil_awvalid,
   output logic                      s_axil_awready,
   input  logic [31:0]               s_axil_wdata,
   input  logic [3:0]                s_axil_wstrb,
   input  logic                      s_axil_wvalid,
   output logic                      s_axil_wready,
   output logic [1:0]                s_axil_bresp,
   output logic                      s_axil_bvalid,
   input  logic                      s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
   input  logic                      s_axil_arvalid,
   output logic                      s_axil_arready,
   output logic [31:0]               s_axil_rdata,
   output logic [1:0]                s_axil_rresp,
   output logic                      s_axil_rvalid,
   input  logic                      s_axil_rready,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [DMA_ADDR_WIDTH-1:0] cmd_src_addr,
   output logic [DMA_ADDR_WIDTH-1:0] cmd_dst_addr,
   output logic [LEN_WIDTH-1:0]      cmd_len,
   output logic                      cmd_dir,
   input  logic                      dma_done,
   input  logic                      dma_err,
   output logic                      irq_req,
   input  logic                      irq_ack
);
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_BUSY, ST_IRQ} state_t;

   localparam logic [7:0] A_START  = 8'h00, A_SRC_LO = 8'h04, A_SRC_HI = 8'h08;
   localparam logic [7:0] A_DST_LO = 8'h0C, A_DST_HI = 8'h10, A_LEN    = 8'h14;
   localparam logic [7:0] A_DIR    = 8'h18, A_STATUS = 8'h1C, A_CLR    = 8'h20;

   state_t state_q, state_d;
   logic aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [7:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0] wstrb_q, wstrb_d;
   logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] src_lo_q, src_lo_d, src_hi_q, src_hi_d, dst_lo_q, dst_lo_d, dst_hi_q, dst_hi_d;
   logic [31:0] len_q, len_d;
   logic dir_q, dir_d, done_q, done_d, err_q, err_d, drop_q, drop_d;
   logic cmd_valid_q, cmd_valid_d, cmd_dir_q, cmd_dir_d, irq_q, irq_d;
   logic [DMA_ADDR_WIDTH-1:0] cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
   logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;
   logic do_write, start_wr, clr_wr;
   logic [63:0] src_full, dst_full;
   logic [31:0] rd_mux;
   logic unused_addr_hi;

   assign unused_addr_hi = ^{s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_araddr[ADDR_WIDTH-1:8]};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Both beats captured and no response pending: commit the write this cycle.
   assign do_write = aw_got_q && w_got_q && !bvalid_q;
   assign start_wr = do_write && (waddr_q == A_START) && wstrb_q[0] && wdata_q[0];
   assign clr_wr   = do_write && (waddr_q == A_CLR) && wstrb_q[0];
   assign src_full = {src_hi_q, src_lo_q};
   assign dst_full = {dst_hi_q, dst_lo_q};

   always_comb begin
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bvalid_d = bvalid_q;
      if (s_axil_awvalid && awready_q) begin
         aw_got_d = 1'b1;
         waddr_d  = s_axil_awaddr[7:0];
      end
      if (s_axil_wvalid && wready_q) begin
         w_got_d = 1'b1;
         wdata_d = s_axil_wdata;
         wstrb_d = s_axil_wstrb;
      end
      if (do_write) begin
         aw_got_d = 1'b0;
         w_got_d  = 1'b0;
         bvalid_d = 1'b1;
      end else if (bvalid_q && s_axil_bready) begin
         bvalid_d = 1'b0;
      end
      awready_d = !aw_got_d && !bvalid_d;
      wready_d  = !w_got_d && !bvalid_d;
   end

   always_comb begin
      src_lo_d = src_lo_q;
      src_hi_d = src_hi_q;
      dst_lo_d = dst_lo_q;
      dst_hi_d = dst_hi_q;
      len_d    = len_q;
      dir_d    = dir_q;
      if (do_write) begin
         case (waddr_q)
            A_SRC_LO: src_lo_d = merge(src_lo_q, wdata_q, wstrb_q);
            A_SRC_HI: src_hi_d = merge(src_hi_q, wdata_q, wstrb_q);
            A_DST_LO: dst_lo_d = merge(dst_lo_q, wdata_q, wstrb_q);
            A_DST_HI: dst_hi_d = merge(dst_hi_q, wdata_q, wstrb_q);
            A_LEN:    len_d    = merge(len_q, wdata_q, wstrb_q);
            A_DIR:    if (wstrb_q[0]) dir_d = wdata_q[0];
            default:  ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_src_d   = cmd_src_q;
      cmd_dst_d   = cmd_dst_q;
      cmd_len_d   = cmd_len_q;
      cmd_dir_d   = cmd_dir_q;
      done_d      = done_q;
      err_d       = err_q;
      drop_d      = drop_q;
      // Clears are applied first so a same-cycle set event overrides them.
      if (clr_wr) begin
         if (wdata_q[1]) done_d = 1'b0;
         if (wdata_q[2]) err_d  = 1'b0;
         if (wdata_q[3]) drop_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: if (start_wr) begin
            if (len_q == 32'd0) begin
               done_d  = 1'b1;
               state_d = ST_IRQ;
            end else begin
               cmd_src_d   = src_full[DMA_ADDR_WIDTH-1:0];
               cmd_dst_d   = dst_full[DMA_ADDR_WIDTH-1:0];
               cmd_len_d   = len_q[LEN_WIDTH-1:0];
               cmd_dir_d   = dir_q;
               cmd_valid_d = 1'b1;
               state_d     = ST_CMD;
            end
         end
         ST_CMD: if (cmd_ready) begin
            cmd_valid_d = 1'b0;
            state_d     = ST_BUSY;
         end
         ST_BUSY: if (dma_done) begin
            done_d  = 1'b1;
            if (dma_err) err_d = 1'b1;
            state_d = ST_IRQ;
         end
         ST_IRQ: if (irq_ack) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (start_wr && state_q != ST_IDLE) drop_d = 1'b1;
      irq_d = (state_d == ST_IRQ);
   end

   always_comb begin
      rd_mux = 32'd0;
      case (s_axil_araddr[7:0])
         A_SRC_LO: rd_mux = src_lo_q;
         A_SRC_HI: rd_mux = src_hi_q;
         A_DST_LO: rd_mux = dst_lo_q;
         A_DST_HI: rd_mux = dst_hi_q;
         A_LEN:    rd_mux = len_q;
         A_DIR:    rd_mux = {31'd0, dir_q};
         A_STATUS: rd_mux = {28'd0, drop_q, err_q, done_q, state_q != ST_IDLE};
         default:  rd_mux = 32'd0;
      endcase
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (s_axil_arvalid && arready_q) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && s_axil_rready) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         aw_got_q <= 1'b0;  w_got_q <= 1'b0;  waddr_q <= '0;  wdata_q <= '0;  wstrb_q <= '0;
         awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
         arready_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0;
         src_lo_q <= '0; src_hi_q <= '0; dst_lo_q <= '0; dst_hi_q <= '0; len_q <= '0;
         dir_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; drop_q <= 1'b0;
         cmd_valid_q <= 1'b0; cmd_src_q <= '0; cmd_dst_q <= '0; cmd_len_q <= '0;
         cmd_dir_q <= 1'b0; irq_q <= 1'b0;
      end else begin
         state_q <= state_d;
         aw_got_q <= aw_got_d; w_got_q <= w_got_d; waddr_q <= waddr_d;
         wdata_q <= wdata_d;   wstrb_q <= wstrb_d;
         awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
         arready_q <= arready_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d;
         src_lo_q <= src_lo_d; src_hi_q <= src_hi_d; dst_lo_q <= dst_lo_d;
         dst_hi_q <= dst_hi_d; len_q <= len_d;
         dir_q <= dir_d; done_q <= done_d; err_q <= err_d; drop_q <= drop_d;
         cmd_valid_q <= cmd_valid_d; cmd_src_q <= cmd_src_d; cmd_dst_q <= cmd_dst_d;
         cmd_len_q <= cmd_len_d; cmd_dir_q <= cmd_dir_d; irq_q <= irq_d;
      end
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = 2'b00;
   assign s_axil_arready = arready_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = 2'b00;
   assign cmd_valid      = cmd_valid_q;
   assign cmd_src_addr   = cmd_src_q;
   assign cmd_dst_addr   = cmd_dst_q;
   assign cmd_len        = cmd_len_q;
   assign cmd_dir        = cmd_dir_q;
   assign irq_req        = irq_q;
endmodule

// File: doc/rp_dma_ctrl_regs.md
Name: rp_dma_ctrl_regs

Overview:
- AXI4-Lite register slave plus a control FSM for the card-side DMA engine.
- Software programs source, destination, length and direction, then writes START.
- The block latches these values into a command, hands the command to the DMA engine over a valid/ready handshake, waits for the engine's done pulse, and raises a host interrupt request that is held until acknowledged.
- It sits between the shell's AXI-Lite user BAR and the DMA datapath, which is the block immediately downstream.

Parameters:
- ADDR_WIDTH, 16: AXI-Lite address width. Decode uses bits [7:0]; upper bits are ignored.
- DMA_ADDR_WIDTH, 64: width of the source and destination addresses in the command.
- LEN_WIDTH, 32: width of the byte-length field.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awvalid / s_axil_awready  in/out  1  write-address handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid / s_axil_wready  in/out  1  write-data handshake.
- s_axil_bresp  out  2  always 2'b00.
- s_axil_bvalid / s_axil_bready  out/in  1  write-response handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arvalid / s_axil_arready  in/out  1  read-address handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  always 2'b00.
- s_axil_rvalid / s_axil_rready  out/in  1  read-data handshake.
- cmd_valid  out  1  DMA command valid.
- cmd_ready  in  1  DMA engine accepts the command.
- cmd_src_addr  out  DMA_ADDR_WIDTH  latched source address.
- cmd_dst_addr  out  DMA_ADDR_WIDTH  latched destination address.
- cmd_len  out  LEN_WIDTH  latched byte count.
- cmd_dir  out  1  0 = c2h, 1 = h2c.
- dma_done  in  1  one-cycle pulse: engine finished the current command.
- dma_err  in  1  sampled together with dma_done; 1 means the transfer failed.
- irq_req  out  1  interrupt request (vector 0), level.
- irq_ack  in  1  one-cycle acknowledge from the shell.

Behaviour:
- Register map, byte addresses, 32-bit registers:
  - 0x00 START: write with wstrb[0]=1 and wdata[0]=1 requests a start. Reads return 0.
  - 0x04 SRC_LSB, 0x08 SRC_MSB: source address.
  - 0x0C DST_LSB, 0x10 DST_MSB: destination address.
  - 0x14 LEN: byte count.
  - 0x18 DIRECTION: bit0 only.
  - 0x1C STATUS, read-only: bit0 busy (state != IDLE); bit1 done sticky; bit2 err sticky; bit3 start_dropped sticky.
  - 0x20 STATUS_CLR: write-1-to-clear bits [3:1].
  - Any other address: writes are ignored, reads return 0, response is still OKAY.
- Configuration registers honour wstrb per byte. They are writable in any state; only the values latched at START are presented on cmd_*.
- Write channel:
  - AW and W are accepted independently; each ready is high while its beat is not yet captured and bvalid=0.
  - The register update happens in the cycle after both beats are captured; bvalid rises in that same cycle and holds until bready.
  - Only one write is outstanding at a time.
- Read channel:
  - arready=1 when rvalid=0.
  - rdata is registered; rvalid asserts the cycle after the AR handshake and holds until rready.
- Reset values: all ready/valid outputs 0, cmd_* 0, irq_req 0, all registers 0, FSM in IDLE.
  - awready, wready and arready rise in the first cycle after reset is released.
- FSM states:
  - IDLE, on accepted START:
    - If LEN==0: go to IRQ; done sticky=1; no command is issued.
    - Otherwise: latch SRC, DST, LEN, DIRECTION into cmd_*, assert cmd_valid, go to CMD.
  - CMD: hold cmd_valid and cmd_* stable until cmd_ready. On cmd_valid&&cmd_ready, deassert cmd_valid next cycle and go to BUSY.
  - BUSY: on dma_done, set done sticky and set err sticky if dma_err, then go to IRQ. irq_req=1 from the next cycle.
  - IRQ: hold irq_req=1 until irq_ack, then irq_req=0 and go to IDLE in the following cycle.
- START accepted in any state other than IDLE: ignored and start_dropped sticky is set. The FSM and cmd_* are unaffected.
- dma_done outside BUSY: ignored.
- irq_ack outside IRQ: ignored.
- STATUS_CLR write in the same cycle as a set event: the set wins.
- Minimum latency from START write update to cmd_valid is 1 cycle; cmd_valid is registered.
- Reset asserted mid-operation: next edge returns to IDLE, drops cmd_valid and irq_req, and clears every register and sticky bit. Any pending AXI-Lite response is discarded.

Test Plan:
- Reset then read STATUS -> rdata 0x0; awready, wready, arready = 1 within 1 cycle of reset release.
- Program SRC=0x0, DST=0x1_0000_0040, LEN=0x1234, DIR=1, then START; hold cmd_ready=0 for 5 cycles -> cmd_valid held with cmd_src_addr=0x0, cmd_dst_addr=0x1_0000_0040, cmd_len=0x1234, cmd_dir=1; STATUS=0x1 during the stall.
- Assert cmd_ready, then pulse dma_done with dma_err=0 -> irq_req=1 the next cycle, STATUS=0x3; pulse irq_ack -> irq_req=0, STATUS=0x2; write STATUS_CLR=0xE -> STATUS=0x0.
- START while BUSY, plus a write LEN=0x10 -> cmd_len stays 0x1234, STATUS bit3=1; after completion the next START issues cmd_len=0x10.
- LEN=0, START -> no cmd_valid; irq_req=1; STATUS=0x3.
- AW presented 3 cycles before W, with wstrb=4'b0011 and wdata=0xAABBCCDD to LEN=0x11223344 -> LEN reads 0x1122CCDD; a single bvalid. Read of unmapped 0x40 -> rdata 0, rresp 0.
